ysyx_23060042_isram: RTL and testbench

Instruction-side memory responder: the target end of the IFU fetch interface. It accepts one word-read request at a time over a valid/ready handshake and returns the 32-bit instruction word after a fixed or pseudo-random latency, with an error flag for misaligned or out-of-range addresses. It sits between `ysyx_23060042_IFU` and the simulation memory image, and replaces the zero-latency combinational fetch path.

---
 rtl/ysyx_23060042_mem_pkg.sv | 28 ++
 rtl/ysyx_23060042_lfsr8.sv | 28 ++
 rtl/ysyx_23060042_isram.sv | 130 +++++++++++++
 tb/tb_ysyx_23060042_isram.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060042_mem_pkg.sv
// rtl/ysyx_23060042_mem_pkg.sv - shared memory-side types, constants and LFSR step
package ysyx_23060042_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } isram_state_t;

  localparam logic [31:0] MEM_BASE_ADDR = 32'h80000000;
  localparam logic [7:0]  LFSR_SEED     = 8'hA5;

  // Fetch handshake payloads, shared with the data-side memory responder.
  typedef struct packed {
    logic [31:0] addr;
  } fetch_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_resp_t;

  // One step of the 8-bit Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/ysyx_23060042_lfsr8.sv
// rtl/ysyx_23060042_lfsr8.sv - enable-stepped 8-bit LFSR, reseeded on reset
module ysyx_23060042_lfsr8
  import ysyx_23060042_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] value_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Advance only when asked, so the sequence depends on request count alone.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = lfsr8_next(lfsr_q);
  end

  // State register, seeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/ysyx_23060042_isram.sv
// rtl/ysyx_23060042_isram.sv - IFU fetch responder with latency; ISRAM_RAND_DELAY_EN selects LFSR latency
module ysyx_23060042_isram
  import ysyx_23060042_mem_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(MEM_BASE_ADDR),
  parameter int                DEPTH_LOG2 = 16,
  parameter int                LATENCY    = 1,
  parameter string             INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  isram_state_t            state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;

  logic [ADDR_W-1:0]       req_off;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_err;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DATA_W-1:0]       rd_word;
  logic                    accept;
  logic [3:0]              lat;

  // The offset wraps below BASE_ADDR; the compare and upper-bit test both catch it.
  assign req_off = req_addr - BASE_ADDR;
  assign req_idx = req_off[DEPTH_LOG2+1:2];
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                   ((req_off >> (DEPTH_LOG2 + 2)) != '0);

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_val;

  ysyx_23060042_lfsr8 u_lfsr (
    .clk     (clk),
    .rst_n   (rst),
    .en      (accept),
    .value_o (lfsr_val)
  );

  assign lat = 4'd1 + {1'b0, lfsr_val[2:0]};
`else
  assign lat = 4'(LATENCY);
`endif

  // Single array read port: request index on a 1-cycle accept, latched index otherwise.
  assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_word = mem[rd_idx];

  // Next-state and response-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          idx_d  = req_idx;
          err_d  = req_err;
          if (lat <= 4'd1) begin
            state_d     = RESP;
            resp_data_d = req_err ? '0 : rd_word;
            resp_err_d  = req_err;
          end else begin
            cnt_d   = lat - 4'd2;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          resp_data_d = err_q ? '0 : rd_word;
          resp_err_d  = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready  = rst && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_23060042_isram.sv
// tb/tb_ysyx_23060042_isram.sv - directed table-driven bench for ysyx_23060042_isram
module tb_ysyx_23060042_isram;

  localparam int          LAT   = 3;
  localparam int          DLOG  = 4;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] gold = 8'hA5;

  typedef struct {
    logic [31:0] addr;
    int          bp;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  ysyx_23060042_isram #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE),
    .DEPTH_LOG2(DLOG), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input int i);
    return 32'h00000413 ^ (32'(i) * 32'h01010100);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_lat(output int l);
`ifdef ISRAM_RAND_DELAY_EN
    l    = 1 + int'(gold[2:0]);
    gold = {gold[6:0], gold[7] ^ gold[5] ^ gold[4] ^ gold[3]};
`else
    l = LAT;
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int   lat_exp;
    int   n;
    logic seen;
    logic [31:0] d0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    resp_ready = (v.bp == 0);
    #1 chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hDEADBEEF;
    next_lat(lat_exp);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (resp_valid) seen = 1'b1;
    end
    chk("resp_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      chk("latency", 32'(n), 32'(lat_exp));
      chk("resp_data", resp_data, v.exp_data);
      chk("resp_err", {31'b0, resp_err}, {31'b0, v.exp_err});
      d0 = resp_data;
      for (int b = 0; b < v.bp; b++) begin
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid", {31'b0, resp_valid}, 32'd1);
        chk("bp_data", resp_data, d0);
        chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_valid", {31'b0, resp_valid}, 32'd0);
      chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << DLOG); i++) dut.mem[i] = img(i);

    vecs[0] = '{32'h80000000, 0, 32'h00000413, 1'b0};
    vecs[1] = '{32'h80000004, 5, img(1),       1'b0};
    vecs[2] = '{32'h8000003C, 0, img(15),      1'b0};
    vecs[3] = '{32'h80000002, 0, 32'h0,        1'b1};
    vecs[4] = '{32'h7FFFFFFC, 0, 32'h0,        1'b1};
    vecs[5] = '{32'h80000040, 0, 32'h0,        1'b1};
    vecs[6] = '{32'h00000000, 0, 32'h0,        1'b1};
    vecs[7] = '{32'h80000008, 0, img(2),       1'b0};

    // Reset held for three cycles, all outputs low.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    end
    rst  = 1'b1;
    gold = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset one cycle after accept: the pending response must never appear.
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h80000004;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    gold = 8'hA5;
    #1;
    chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("after_rst_valid", {31'b0, resp_valid}, 32'd0);
    end
    run_vec('{32'h80000008, 0, img(2), 1'b0});
    run_vec('{32'h80000014, 2, img(5), 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
